mem_ctrl: RTL and testbench

//  Byte-wide memory arbiter between icache, dcache and the single-port RAM/IO bus.
//  - Streams one byte per cycle to whichever cache is granted.
//  - dcache has strict priority over icache.
//  - Tracks the one in-flight RAM read so each response returns to the port that issued it.
//  - Blocks IO-space (addr[17:16]==2'b11) accesses while the IO buffer is full.

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 45 ++++
 rtl/mem_ctrl.sv | 87 ++++++++
 tb/tb_mem_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared tags, address-space codes and helpers for the memory controller.
package mem_ctrl_pkg;

  localparam int unsigned TAG_W = 2;

  localparam logic [TAG_W-1:0] TAG_IDLE = 2'b00;
  localparam logic [TAG_W-1:0] TAG_IC   = 2'b01;
  localparam logic [TAG_W-1:0] TAG_DC   = 2'b10;

  // Top two address bits selecting the IO space
  localparam logic [1:0] IO_SPACE = 2'b11;

  // Owner of the single outstanding RAM access
  typedef enum logic [TAG_W-1:0] {
    ST_IDLE = TAG_IDLE,
    ST_IC   = TAG_IC,
    ST_DC   = TAG_DC
  } tag_e;

  // True when the address-space bits point at IO
  function automatic logic is_io(input logic [1:0] space);
    return space == IO_SPACE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Combinational grant and RAM/IO bus mux: dcache over icache, IO blocked while buffer full.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 18
) (
  input  logic              issue_en,
  input  logic              io_buffer_full,
  input  logic              ic_get_en,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              dc_get_en,
  input  logic              dc_write_mode,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [7:0]        dc_data,
  output tag_e              grant,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr
);

  logic dc_blocked;

  // dcache IO accesses must wait for room in the IO buffer
  assign dc_blocked = is_io(dc_addr[ADDR_W-1 -: 2]) && io_buffer_full;

  // Pick the winner and steer its address/data onto the bus
  always_comb begin
    grant    = ST_IDLE;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (issue_en) begin
      if (dc_get_en && !dc_blocked) begin
        grant    = ST_DC;
        mem_a    = dc_addr;
        mem_dout = dc_data;
        mem_wr   = dc_write_mode;
      end else if (ic_get_en) begin
        grant = ST_IC;
        mem_a = ic_addr;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide icache/dcache arbiter for the single-port RAM/IO bus with in-flight tagging.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hci_rdy,
  input  logic              io_buffer_full,
  input  logic              ic_get_en,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_out_en,
  output logic [7:0]        ic_content,
  input  logic              dc_get_en,
  input  logic              dc_write_mode,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [7:0]        dc_data,
  output logic              dc_out_en,
  output logic [7:0]        dc_content,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [CNT_W-1:0]  dbg_rd_cnt,
  output logic [CNT_W-1:0]  dbg_wr_cnt
);

  tag_e             grant;
  tag_e             tag_q, tag_d;
  logic             issue_en;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Nothing goes on the bus while frozen or held in reset
  assign issue_en = hci_rdy && !rst;

  mem_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .issue_en       (issue_en),
    .io_buffer_full (io_buffer_full),
    .ic_get_en      (ic_get_en),
    .ic_addr        (ic_addr),
    .dc_get_en      (dc_get_en),
    .dc_write_mode  (dc_write_mode),
    .dc_addr        (dc_addr),
    .dc_data        (dc_data),
    .grant          (grant),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr)
  );

  // Next tag is this cycle's grant; counters advance per issued byte
  always_comb begin
    tag_d    = grant;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (grant != ST_IDLE) begin
      if (mem_wr) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      else        rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
  end

  // Tag and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= ST_IDLE;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      tag_q    <= tag_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign ic_out_en  = (tag_q == ST_IC);
  assign dc_out_en  = (tag_q == ST_DC);
  assign ic_content = mem_din;
  assign dc_content = mem_din;
  assign dbg_rd_cnt = rd_cnt_q;
  assign dbg_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural RAM on the bus.
module tb_mem_ctrl;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              hci_rdy;
  logic              io_buffer_full;
  logic              ic_get_en;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_out_en;
  logic [7:0]        ic_content;
  logic              dc_get_en;
  logic              dc_write_mode;
  logic [ADDR_W-1:0] dc_addr;
  logic [7:0]        dc_data;
  logic              dc_out_en;
  logic [7:0]        dc_content;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic [CNT_W-1:0]  dbg_rd_cnt;
  logic [CNT_W-1:0]  dbg_wr_cnt;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .hci_rdy        (hci_rdy),
    .io_buffer_full (io_buffer_full),
    .ic_get_en      (ic_get_en),
    .ic_addr        (ic_addr),
    .ic_out_en      (ic_out_en),
    .ic_content     (ic_content),
    .dc_get_en      (dc_get_en),
    .dc_write_mode  (dc_write_mode),
    .dc_addr        (dc_addr),
    .dc_data        (dc_data),
    .dc_out_en      (dc_out_en),
    .dc_content     (dc_content),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .dbg_rd_cnt     (dbg_rd_cnt),
    .dbg_wr_cnt     (dbg_wr_cnt)
  );

  // RAM: read data one cycle after address, write on strobe
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] <= mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, land just after the edge, then let combinational paths settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    ram[18'h00100] = 8'hAA;
    ram[18'h00101] = 8'hBB;
    ram[18'h00102] = 8'hCC;
    ram[18'h00103] = 8'hDD;
    ram[18'h00104] = 8'hEE;
    ram[18'h00300] = 8'h77;

    rst = 1'b1; hci_rdy = 1'b1; io_buffer_full = 1'b0;
    ic_get_en = 1'b0; ic_addr = '0;
    dc_get_en = 1'b0; dc_write_mode = 1'b0; dc_addr = '0; dc_data = '0;
    tick(); tick();

    // Reset state
    chk("rst_ic_out_en", 32'(ic_out_en), 32'd0);
    chk("rst_dc_out_en", 32'(dc_out_en), 32'd0);
    chk("rst_mem_wr",    32'(mem_wr),    32'd0);
    chk("rst_mem_a",     32'(mem_a),     32'd0);
    chk("rst_rd_cnt",    dbg_rd_cnt,     32'd0);
    chk("rst_wr_cnt",    dbg_wr_cnt,     32'd0);
    rst = 1'b0;
    tick();

    // 1: icache burst 0x100..0x103
    ic_get_en = 1'b1; ic_addr = 18'h00100; settle();
    chk("t1_issue_a0", 32'(mem_a),  32'h100);
    chk("t1_issue_wr", 32'(mem_wr), 32'd0);
    tick();
    chk("t1_oe0", 32'(ic_out_en), 32'd1);  chk("t1_b0", 32'(ic_content), 32'hAA);
    ic_addr = 18'h00101; settle();
    chk("t1_issue_a1", 32'(mem_a), 32'h101);
    tick();
    chk("t1_oe1", 32'(ic_out_en), 32'd1);  chk("t1_b1", 32'(ic_content), 32'hBB);
    ic_addr = 18'h00102; tick();
    chk("t1_oe2", 32'(ic_out_en), 32'd1);  chk("t1_b2", 32'(ic_content), 32'hCC);
    ic_addr = 18'h00103; tick();
    chk("t1_oe3", 32'(ic_out_en), 32'd1);  chk("t1_b3", 32'(ic_content), 32'hDD);
    ic_get_en = 1'b0; settle();
    chk("t1_idle_a",  32'(mem_a), 32'd0);
    tick();
    chk("t1_idle_oe", 32'(ic_out_en), 32'd0);
    chk("t1_rd_cnt",  dbg_rd_cnt, 32'd4);

    // 2: dcache write 0x200 = 5A
    dc_get_en = 1'b1; dc_write_mode = 1'b1; dc_addr = 18'h00200; dc_data = 8'h5A; settle();
    chk("t2_wr",   32'(mem_wr),   32'd1);
    chk("t2_a",    32'(mem_a),    32'h200);
    chk("t2_dout", 32'(mem_dout), 32'h5A);
    chk("t2_oe_same", 32'(dc_out_en), 32'd0);
    tick();
    chk("t2_ack", 32'(dc_out_en), 32'd1);
    dc_get_en = 1'b0; dc_write_mode = 1'b0; settle();
    chk("t2_wr_cnt", dbg_wr_cnt, 32'd1);
    chk("t2_ram",    32'(ram[18'h00200]), 32'h5A);
    tick();
    chk("t2_ack_gone", 32'(dc_out_en), 32'd0);

    // 3: icache stream pre-empted by dcache read 0x300 at byte 2
    ic_get_en = 1'b1; ic_addr = 18'h00100; tick();
    chk("t3_b0", 32'(ic_content), 32'hAA);
    ic_addr = 18'h00101; tick();
    chk("t3_b1", 32'(ic_content), 32'hBB);
    ic_addr = 18'h00102;
    dc_get_en = 1'b1; dc_addr = 18'h00300; settle();
    chk("t3_dc_wins_a", 32'(mem_a), 32'h300);
    tick();
    chk("t3_dc_oe",  32'(dc_out_en),  32'd1);
    chk("t3_dc_b",   32'(dc_content), 32'h77);
    chk("t3_ic_nooe", 32'(ic_out_en), 32'd0);
    dc_get_en = 1'b0; settle();
    chk("t3_reissue_a", 32'(mem_a), 32'h102);
    tick();
    chk("t3_oe2", 32'(ic_out_en), 32'd1);  chk("t3_b2", 32'(ic_content), 32'hCC);
    ic_addr = 18'h00103; tick();
    chk("t3_oe3", 32'(ic_out_en), 32'd1);  chk("t3_b3", 32'(ic_content), 32'hDD);
    ic_get_en = 1'b0; tick();
    chk("t3_end_oe", 32'(ic_out_en), 32'd0);
    chk("t3_rd_cnt", dbg_rd_cnt, 32'd9);

    // 4: dcache IO write blocked while IO buffer full
    io_buffer_full = 1'b1;
    dc_get_en = 1'b1; dc_write_mode = 1'b1; dc_addr = 18'h30000; dc_data = 8'h11;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("t4_blk_wr", 32'(mem_wr), 32'd0);
      chk("t4_blk_a",  32'(mem_a),  32'd0);
      tick();
      chk("t4_blk_oe", 32'(dc_out_en), 32'd0);
    end
    io_buffer_full = 1'b0; settle();
    chk("t4_issue_wr", 32'(mem_wr), 32'd1);
    chk("t4_issue_a",  32'(mem_a),  32'h30000);
    tick();
    chk("t4_ack", 32'(dc_out_en), 32'd1);
    dc_get_en = 1'b0; dc_write_mode = 1'b0; settle();
    chk("t4_wr_cnt", dbg_wr_cnt, 32'd2);
    tick();

    // 5: hci_rdy low holds off icache read 0x104
    hci_rdy = 1'b0; ic_get_en = 1'b1; ic_addr = 18'h00104; settle();
    chk("t5_frz_a",  32'(mem_a),  32'd0);
    chk("t5_frz_wr", 32'(mem_wr), 32'd0);
    tick();
    chk("t5_frz_oe0", 32'(ic_out_en), 32'd0);
    tick();
    chk("t5_frz_oe1", 32'(ic_out_en), 32'd0);
    hci_rdy = 1'b1; settle();
    chk("t5_reissue_a", 32'(mem_a), 32'h104);
    tick();
    chk("t5_oe", 32'(ic_out_en),  32'd1);
    chk("t5_b",  32'(ic_content), 32'hEE);
    ic_get_en = 1'b0; tick();
    chk("t5_rd_cnt", dbg_rd_cnt, 32'd10);

    // 6: reset in the middle of a dcache write burst
    dc_get_en = 1'b1; dc_write_mode = 1'b1; dc_addr = 18'h00210; dc_data = 8'h01; tick();
    chk("t6_ack0", 32'(dc_out_en), 32'd1);
    dc_addr = 18'h00211; dc_data = 8'h02;
    rst = 1'b1; settle();
    chk("t6_rst_wr_now", 32'(mem_wr), 32'd0);
    tick();
    chk("t6_dc_oe",  32'(dc_out_en), 32'd0);
    chk("t6_ic_oe",  32'(ic_out_en), 32'd0);
    chk("t6_rd_cnt", dbg_rd_cnt, 32'd0);
    chk("t6_wr_cnt", dbg_wr_cnt, 32'd0);
    chk("t6_mem_wr", 32'(mem_wr), 32'd0);
    dc_get_en = 1'b0; dc_write_mode = 1'b0;
    rst = 1'b0; tick();
    chk("t6_post_oe",  32'(dc_out_en), 32'd0);
    chk("t6_post_cnt", dbg_wr_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
